// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one shared segment/dp bus, per-digit anodes,
// anti-ghost blank phase per slot, per-frame data snapshot and frame_done pulse.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 50000,
  parameter int BLANK      = 500,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic          OFF        = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [4*NUM_DIGITS-1:0] snap_dig, snap_dig_n;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_n, snap_mask, snap_mask_n;
  logic                    take;
  logic [3:0]              cur_dig;
  logic                    cur_dp, cur_mask;
  logic [6:0]              seg_n;
  logic                    dp_n, fd_n;
  logic [NUM_DIGITS-1:0]   an_n;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    take    = 1'b0;
    case (state)
      S_IDLE: if (en) begin
        state_n = S_BLANK; idx_n = '0; cnt_n = '0; take = 1'b1;
      end
      S_BLANK: begin
        if (!en) begin
          state_n = S_IDLE; idx_n = '0; cnt_n = '0;
        end else if (cnt == BLANK_LAST) begin
          state_n = S_SHOW; cnt_n = '0;
        end else cnt_n = cnt + CW'(1);
      end
      S_SHOW: begin
        if (!en) begin
          state_n = S_IDLE; idx_n = '0; cnt_n = '0;
        end else if (cnt == SHOW_LAST) begin
          state_n = S_BLANK; cnt_n = '0;
          // Frame boundary: wrap and resnapshot so the next frame is tear-free
          if (idx == IDX_LAST) begin
            idx_n = '0; take = 1'b1;
          end else idx_n = idx + IW'(1);
        end else cnt_n = cnt + CW'(1);
      end
      default: begin
        state_n = S_IDLE; idx_n = '0; cnt_n = '0;
      end
    endcase

    snap_dig_n  = take ? digits_in  : snap_dig;
    snap_dp_n   = take ? dp_in      : snap_dp;
    snap_mask_n = take ? blank_mask : snap_mask;

    cur_dig  = '0;
    cur_dp   = 1'b0;
    cur_mask = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_n == IW'(i)) begin
        cur_dig  = snap_dig_n[4*i +: 4];
        cur_dp   = snap_dp_n[i];
        cur_mask = snap_mask_n[i];
      end

    // Outputs are computed for the upcoming state so they can be registered
    seg_n = {7{OFF}};
    dp_n  = OFF;
    an_n  = {NUM_DIGITS{OFF}};
    if (state_n != S_IDLE) begin
      seg_n = hex7(cur_dig) ^ {7{OFF}};
      dp_n  = cur_dp ^ OFF;
    end
    if (state_n == S_SHOW && !cur_mask)
      an_n = (NUM_DIGITS'(1) << idx_n) ^ {NUM_DIGITS{OFF}};
    fd_n = (state_n == S_SHOW) && (idx_n == IDX_LAST) && (cnt_n == SHOW_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      snap_dig   <= '0;
      snap_dp    <= '0;
      snap_mask  <= '0;
      seg_out    <= {7{OFF}};
      dp_out     <= OFF;
      an_out     <= {NUM_DIGITS{OFF}};
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      snap_dig   <= snap_dig_n;
      snap_dp    <= snap_dp_n;
      snap_mask  <= snap_mask_n;
      seg_out    <= seg_n;
      dp_out     <= dp_n;
      an_out     <= an_n;
      frame_done <= fd_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl; expected outputs come from a frame-position model
// (position within frame -> digit, slot phase, frame_done) with per-frame snapshots.
module tb_seg_scan_ctrl;
  localparam int N    = 4;
  localparam int DIV  = 8;
  localparam int BLK  = 2;
  localparam int AL   = 1;
  localparam int FLEN = N * DIV;

  localparam logic [6:0] HEX_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]   dp_in, blank_mask;
  logic [6:0]     seg_out;
  logic           dp_out;
  logic [N-1:0]   an_out;
  logic           frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  bit           m_active = 0;
  int           m_p      = 0;
  logic [15:0]  m_dig    = '0;
  logic [N-1:0] m_dp     = '0, m_mask = '0;

  seg_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIV), .BLANK(BLK), .ACTIVE_LOW(AL)) dut (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
    .blank_mask(blank_mask), .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) m_active = 0;
    else if (!m_active) begin
      if (en) begin
        m_active = 1; m_p = 0; m_dig = digits_in; m_dp = dp_in; m_mask = blank_mask;
      end
    end else if (!en) m_active = 0;
    else begin
      m_p++;
      if (m_p == FLEN) begin
        m_p = 0; m_dig = digits_in; m_dp = dp_in; m_mask = blank_mask;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [6:0]   e_seg;
    logic         e_dp, e_fd;
    logic [N-1:0] e_an;
    logic [15:0]  dg;
    int d, w;
    e_seg = 7'h7F; e_dp = 1'b1; e_an = '1; e_fd = 1'b0;
    if (m_active) begin
      d = m_p / DIV; w = m_p % DIV; dg = m_dig;
      e_seg = ~HEX_TBL[dg[4*d +: 4]];
      e_dp  = ~m_dp[d];
      if (w >= BLK && !m_mask[d]) e_an = ~(N'(1) << d);
      e_fd  = (m_p == FLEN - 1);
    end
    chk({tag, ".seg"}, 32'(seg_out), 32'(e_seg));
    chk({tag, ".dp"},  32'(dp_out),  32'(e_dp));
    chk({tag, ".an"},  32'(an_out),  32'(e_an));
    chk({tag, ".fd"},  32'(frame_done), 32'(e_fd));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  // advance until the model is in the SHOW phase of digit d
  task automatic wait_show(input int d, input string tag);
    int k = 0;
    while (!(m_active && m_p / DIV == d && m_p % DIV >= BLK) && k < 200) begin
      step(tag); k++;
    end
    if (k >= 200) chk({tag, ".timeout"}, 0, 1);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; digits_in = '0; dp_in = '0; blank_mask = '0;
    #1 rst = 1'b1;
    #1 check_outputs("reset_noclk");
    en = 1'b1;
    repeat (5) step("reset_hold");
    rst = 1'b0;
    digits_in = 16'h1234;
    repeat (36) step("frame_1234");

    wait_show(1, "to_d1");
    digits_in = 16'hABCD;
    repeat (40) step("snap_abcd");

    wait_show(2, "to_d2");
    en = 1'b0;
    repeat (2) step("en_off");
    en = 1'b1;
    repeat (12) step("re_en");

    blank_mask = 4'b0010; dp_in = 4'b0001;
    repeat (70) step("mask_dp");

    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 3) == 0) digits_in = 16'($urandom);
      if ($urandom_range(0, 9) == 0) dp_in = N'($urandom);
      if ($urandom_range(0, 9) == 0) blank_mask = N'($urandom);
      step("rand");
    end

    en = 1'b1;
    wait_show(1, "to_async");
    #2 rst = 1'b1;
    #1 m_active = 0;
    check_outputs("async_rst");
    step("rst_held");
    rst = 1'b0;
    repeat (40) step("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed 7-segment display scan controller for the FPGA board top.
- Drives NUM_DIGITS hex digits over one shared segment/decimal-point bus with per-digit anode enables.
- Replaces the one-decoder-per-digit, all-digits-static scheme for boards with shared segment lines.
- Sequences digit slots with an anti-ghosting blank phase, snapshots display data once per frame (tear-free), and signals frame completion.

Parameters:
NUM_DIGITS, 8, digits scanned; legal range 1..16
DIV, 50000, clock cycles per digit slot (blank + show)
BLANK, 500, clock cycles at slot start with anodes off; require 1 <= BLANK < DIV
ACTIVE_LOW, 1, 1 = seg/dp/anode outputs active-low; 0 = active-high

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  scan enable; 0 = display dark
digits_in  in  4*NUM_DIGITS  hex nibbles; digit i = digits_in[4i+3:4i]
dp_in  in  NUM_DIGITS  decimal point per digit
blank_mask  in  NUM_DIGITS  1 = digit i kept dark during its slot
seg_out  out  7  segments; bit0 = a ... bit6 = g
dp_out  out  1  decimal point
an_out  out  NUM_DIGITS  anode enables, one-hot when lit
frame_done  out  1  one-cycle pulse in last cycle of a frame

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high. All outputs registered.
- Off level:
  - All-off means every seg/dp/anode bit is at its inactive level.
  - Inactive level is 1 when ACTIVE_LOW = 1, 0 when ACTIVE_LOW = 0.
- Reset and rst assertion at any time, without waiting for a clock edge:
  - State IDLE, digit index 0, slot counter 0.
  - seg_out, dp_out, an_out all-off.
  - frame_done = 0.
  - Snapshot registers = 0.
- Hex encoding (active-high form, inverted when ACTIVE_LOW = 1):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- FSM states:
  - IDLE:
    - Outputs all-off.
    - When en = 1 on a clock edge, go to BLANK with index 0.
    - On that same edge, snapshot digits_in, dp_in and blank_mask.
  - BLANK:
    - an_out all-off.
    - seg_out/dp_out already drive the snapshot value of the current digit.
    - Lasts BLANK cycles, then go to SHOW.
  - SHOW:
    - an_out asserts only bit [index], unless snapshot blank_mask[index] = 1, in which case anodes stay all-off.
    - Lasts DIV-BLANK cycles.
    - At the end: if index < NUM_DIGITS-1, index+1 and go to BLANK.
    - Otherwise: frame_done = 1 for this final SHOW cycle, index wraps to 0, fresh snapshot taken on that edge, go to BLANK.
- Timing:
  - Frame length is exactly NUM_DIGITS*DIV cycles.
  - Enable latency: en sampled 1 on edge k → BLANK of digit 0 visible after edge k.
- Data coherence:
  - Changes on digits_in, dp_in or blank_mask mid-frame have no visible effect until the next frame snapshot.
- en = 0 in any non-IDLE state:
  - Next edge goes to IDLE, outputs all-off, index and counter cleared.
  - No frame_done pulse.
  - Re-enable always restarts at digit 0 with a new snapshot.
- Simultaneity:
  - en falling on the final SHOW cycle: frame_done still pulses (already registered for that cycle), then IDLE.
  - rst overrides everything.
- Slot counter width is ceil(log2(DIV)). Counter reloads at each state change. No wrap-around artefacts.

Test Plan:
Config for all tests: NUM_DIGITS=4, DIV=8, BLANK=2, ACTIVE_LOW=1.
1. Reset: rst=1 with no clock → seg_out=7F, dp_out=1, an_out=F, frame_done=0; hold through 5 clock edges with en=1 → unchanged.
2. digits_in=16'h1234, dp_in=0, en=1:
   - Digit 0 shows 4: seg=19, an=F for 2 cycles, then an=E for 6 cycles.
   - Digit 1 shows 3: seg=30, an=D.
   - Digit 2 shows 2: seg=24, an=B.
   - Digit 3 shows 1: seg=79, an=7.
   - frame_done pulses exactly on cycle 32 of the frame, then digit 0 repeats.
3. Change digits_in to 16'hABCD during digit-1 SHOW → digits 2 and 3 still show 2 and 1; next frame digit 0 shows D: seg=21.
4. Deassert en during digit-2 SHOW → next edge an=F, seg=7F, no frame_done; reassert → restarts with digit 0 BLANK.
5. blank_mask=4'b0010, dp_in=4'b0001 → an never equals D and frame period stays 32 cycles; dp_out=0 only during digit 0's slot.
6. Assert rst asynchronously mid-SHOW → an_out=F immediately, before the next edge; after release with en=1, scanning resumes from digit 0.
